// File: rtl/csam_mul8_sequencer.sv
// Drives one shared 4x4 carry-save multiplier over four clocks (LL, HL, LH, HH)
// and shift-accumulates the partial products into a 2N x 2N product.
module csam_mul8_sequencer #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [4*N-1:0] product,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [2*N-1:0] mul_p
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     step_q, step_d;
   logic [2*N-1:0] a_q, a_d;
   logic [2*N-1:0] b_q, b_d;
   logic [4*N-1:0] acc_q, acc_d;
   logic [4*N-1:0] product_q, product_d;

   logic [4*N-1:0] pp_ext;
   logic [4*N-1:0] pp_shifted;
   logic [4*N-1:0] acc_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         step_q    <= 2'd0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   // Cross terms (HL, LH) carry weight 2^N; HH carries weight 2^(2N).
   always_comb begin
      pp_ext = {{(2*N){1'b0}}, mul_p};
      case (step_q)
         2'd0:    pp_shifted = pp_ext;
         2'd1,
         2'd2:    pp_shifted = pp_ext << N;
         default: pp_shifted = pp_ext << (2*N);
      endcase
      acc_sum = acc_q + pp_shifted;
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      product_d = product_q;
      busy      = 1'b0;
      done      = 1'b0;
      mul_a     = '0;
      mul_b     = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               step_d  = 2'd0;
               state_d = S_MUL;
            end
         end

         S_MUL: begin
            busy   = 1'b1;
            // step bit 0 picks the A half, bit 1 picks the B half
            mul_a  = step_q[0] ? a_q[2*N-1:N] : a_q[N-1:0];
            mul_b  = step_q[1] ? b_q[2*N-1:N] : b_q[N-1:0];
            acc_d  = acc_sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               product_d = acc_sum;
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign product = product_q;

endmodule

// File: tb/tb_csam_mul8_sequencer.sv
// Self-checking bench for csam_mul8_sequencer: table-driven transactions plus
// hand-written back-to-back and mid-operation reset sequences against an a*b model.
module tb_csam_mul8_sequencer;

   localparam int N = 4;

   typedef struct {
      logic [7:0]  opA;
      logic [7:0]  opB;
      logic [15:0] prod;
      bit          disturb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [3:0]  mulA;
   logic [3:0]  mulB;
   logic [7:0]  mulP;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] lastProduct;
   vec_t        vecs[12];

   csam_mul8_sequencer #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rstN),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .mul_a   (mulA),
      .mul_b   (mulB),
      .mul_p   (mulP)
   );

   // Stand-in for the external shared 4x4 array multiplier
   assign mulP = 8'(mulA) * 8'(mulB);

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // One full transaction from IDLE; disturb re-pulses start and scrambles operands while busy
   task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                                input logic [15:0] expProd, input bit disturb);
      logic [3:0] expA[4];
      logic [3:0] expB[4];
      expA[0] = opA[3:0]; expB[0] = opB[3:0];
      expA[1] = opA[7:4]; expB[1] = opB[3:0];
      expA[2] = opA[3:0]; expB[2] = opB[7:4];
      expA[3] = opA[7:4]; expB[3] = opB[7:4];

      start = 1'b1;
      a     = opA;
      b     = opB;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("mul_busy_k%0d", k), busy, 1);
         checkOutput($sformatf("mul_done_k%0d", k), done, 0);
         checkOutput($sformatf("mul_product_hold_k%0d", k), product, lastProduct);
         checkOutput($sformatf("mul_a_k%0d", k), mulA, expA[k]);
         checkOutput($sformatf("mul_b_k%0d", k), mulB, expB[k]);
         if (disturb) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            start = (k == 1 || k == 3);
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("done_pulse", done, 1);
      checkOutput("done_busy", busy, 1);
      checkOutput("done_product", product, expProd);
      checkOutput("done_mul_a_quiet", mulA, 0);
      checkOutput("done_mul_b_quiet", mulB, 0);
      @(negedge clk);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_product", product, expProd);
      checkOutput("idle_mul_a_quiet", mulA, 0);
      if (disturb) begin
         @(negedge clk);
         checkOutput("no_requeue_busy", busy, 0);
         checkOutput("no_requeue_done", done, 0);
      end
      lastProduct = expProd;
   endtask

   initial begin
      int rem;
      int doneCount;

      vecs[0] = '{8'h00, 8'h00, 16'h0000, 1'b0};
      vecs[1] = '{8'h01, 8'h06, 16'h0006, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
      vecs[3] = '{8'h15, 8'h2E, 16'h03C6, 1'b1};
      for (int i = 4; i < 12; i++) begin
         vecs[i].opA     = 8'($urandom);
         vecs[i].opB     = 8'($urandom);
         vecs[i].prod    = 16'(vecs[i].opA) * 16'(vecs[i].opB);
         vecs[i].disturb = 1'($urandom_range(0, 1));
      end

      rstN  = 1'b0;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      #12;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_product", product, 0);
      checkOutput("reset_mul_a", mulA, 0);
      checkOutput("reset_mul_b", mulB, 0);
      @(negedge clk);
      rstN        = 1'b1;
      lastProduct = 16'h0000;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].prod, vecs[i].disturb);
      end

      // start held high: re-accepted each time the block returns to IDLE
      a         = 8'h10;
      b         = 8'h10;
      start     = 1'b1;
      rem       = 0;
      doneCount = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(posedge clk);
         if (rem == 0) begin
            if (start) rem = 5;
         end else begin
            rem = rem - 1;
         end
         @(negedge clk);
         checkOutput($sformatf("b2b_busy_c%0d", cyc), busy, (rem > 0));
         checkOutput($sformatf("b2b_done_c%0d", cyc), done, (rem == 1));
         if (rem == 1) begin
            doneCount++;
            checkOutput($sformatf("b2b_product_c%0d", cyc), product, 16'h0100);
         end
         if (cyc >= 11) start = 1'b0;
      end
      checkOutput("b2b_done_count", doneCount, 2);
      lastProduct = 16'h0100;

      // Reset while step 2 of 0xFF*0xFF is in flight
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_abort_mul_b", mulB, 4'hF);
      rstN = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_product", product, 0);
      checkOutput("abort_mul_a", mulA, 0);
      checkOutput("abort_mul_b", mulB, 0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("post_abort_done", done, 0);
      checkOutput("post_abort_busy", busy, 0);
      lastProduct = 16'h0000;
      applyStimulus(8'h03, 8'h05, 16'h000F, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
